// File: rtl/boot_pkg.sv
// Shared definitions for the boot sequencer: FSM state encoding and the default jump opcode.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_JMP0 = 3'd1,
    ST_JMP1 = 3'd2,
    ST_JMP2 = 3'd3,
    ST_RUN  = 3'd4
  } state_t;

  localparam logic [7:0] JMP_OPCODE_DEF = 8'hC3;

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector: rise is high in the cycle where sig is 1 and was 0 on the previous clock.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/boot_seq.sv
// Boot sequencer: waits for memory init, injects a 3-byte jump on CPU reads, then gates ROM/RAM access.
// Build option: define BOOT_ROM_WP_EN to block RAM write pulses for accesses inside the ROM window.
//
// state | meaning
// INIT  | waiting for mem_init_done or init timeout, CPU held
// JMP0  | injecting jump opcode
// JMP1  | injecting low byte of boot vector
// JMP2  | injecting high byte of boot vector
// RUN   | normal operation, held until reset
module boot_seq
  import boot_pkg::*;
#(
  parameter logic [7:0]  JMP_OPCODE   = JMP_OPCODE_DEF,
  parameter logic [15:0] ROM_BASE     = 16'hFD00,
  parameter int          ROM_PAGES    = 1,
  parameter logic [15:0] INIT_TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] boot_vec,
  input  logic        mem_init_done,
  output logic [7:0]  data_out,
  output logic        inj_valid,
  output logic        rom_cs,
  output logic        ram_we,
  output logic        cpu_ready,
  output logic        boot_done
);

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic [15:0] vec;
  logic        latch_vec;
  logic        rd_rise, wr_rise;
  logic [7:0]  data_next;
  logic        inj_next, ready_next, done_next, we_next;
  logic [16:0] rom_lo, rom_hi;

  edge_det u_rd_edge (.clk(clk), .reset(reset), .sig(rd), .rise(rd_rise));
  edge_det u_wr_edge (.clk(clk), .reset(reset), .sig(wr), .rise(wr_rise));

  // 17-bit bounds so a window ending at 16'hFFFF does not wrap to zero
  assign rom_lo = {1'b0, ROM_BASE};
  assign rom_hi = rom_lo + 17'(ROM_PAGES * 256);
  assign rom_cs = (state == ST_RUN) && ({1'b0, addr} >= rom_lo) && ({1'b0, addr} < rom_hi);

  always_comb begin
    state_next = state;
    latch_vec  = 1'b0;
    case (state)
      ST_INIT: begin
        if (mem_init_done || (wait_cnt == INIT_TIMEOUT - 16'd1)) begin
          state_next = ST_JMP0;
          latch_vec  = 1'b1;
        end
      end
      ST_JMP0: if (rd_rise) state_next = ST_JMP1;
      ST_JMP1: if (rd_rise) state_next = ST_JMP2;
      ST_JMP2: if (rd_rise) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Outputs are registered from the next state so they are stable from state entry
  always_comb begin
    data_next  = 8'h00;
    inj_next   = 1'b0;
    ready_next = 1'b0;
    done_next  = 1'b0;
    case (state_next)
      ST_JMP0: begin data_next = JMP_OPCODE; inj_next = 1'b1; ready_next = 1'b1; end
      ST_JMP1: begin data_next = vec[7:0];   inj_next = 1'b1; ready_next = 1'b1; end
      ST_JMP2: begin data_next = vec[15:8];  inj_next = 1'b1; ready_next = 1'b1; end
      ST_RUN:  begin ready_next = 1'b1; done_next = 1'b1; end
      default: ;
    endcase
`ifdef BOOT_ROM_WP_EN
    we_next = wr_rise && (state == ST_RUN) && !rom_cs;
`else
    we_next = wr_rise && (state == ST_RUN);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      wait_cnt  <= 16'd0;
      vec       <= 16'd0;
      data_out  <= 8'h00;
      inj_valid <= 1'b0;
      cpu_ready <= 1'b0;
      boot_done <= 1'b0;
      ram_we    <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= (state == ST_INIT) ? wait_cnt + 16'd1 : 16'd0;
      if (latch_vec) vec <= boot_vec;
      data_out  <= data_next;
      inj_valid <= inj_next;
      cpu_ready <= ready_next;
      boot_done <= done_next;
      ram_we    <= we_next;
    end
  end

endmodule

// File: tb/tb_boot_seq.sv
// Scoreboard bench for boot_seq: stimulus pushes expected output events, a negedge monitor pops and compares.
module tb_boot_seq;

  localparam logic [15:0] TO    = 16'd8;
  localparam logic [15:0] BASE  = 16'hFD00;
  localparam int          PAGES = 3;
`ifdef BOOT_ROM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0, mem_init_done = 1'b0;
  logic [15:0] addr = 16'h0, boot_vec = 16'h0;
  logic [7:0]  data_out, data_out_hi;
  logic        inj_valid, rom_cs, ram_we, cpu_ready, boot_done;
  logic        inj_valid_hi, rom_cs_hi, ram_we_hi, cpu_ready_hi, boot_done_hi;

  boot_seq #(.ROM_BASE(BASE), .ROM_PAGES(PAGES), .INIT_TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .boot_vec(boot_vec),
    .mem_init_done(mem_init_done), .data_out(data_out), .inj_valid(inj_valid),
    .rom_cs(rom_cs), .ram_we(ram_we), .cpu_ready(cpu_ready), .boot_done(boot_done));

  // second instance only for the top-of-memory ROM window
  boot_seq #(.ROM_BASE(16'hFF00), .ROM_PAGES(1), .INIT_TIMEOUT(TO)) u_dut_hi (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .boot_vec(boot_vec),
    .mem_init_done(mem_init_done), .data_out(data_out_hi), .inj_valid(inj_valid_hi),
    .rom_cs(rom_cs_hi), .ram_we(ram_we_hi), .cpu_ready(cpu_ready_hi), .boot_done(boot_done_hi));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_we;
    logic [10:0] val;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0, errors = 0;
  bit          mon_en = 1'b0;
  logic [10:0] last_obs, obs;
  int          phase = 0;
  logic [15:0] mvec;

  // expected {inj_valid, boot_done, cpu_ready, data_out} for a boot phase (0 init, 1..3 jump bytes, 4 run)
  function automatic logic [10:0] tup_of(int ph, logic [15:0] v);
    logic [7:0] bytes [3];
    bytes[0] = 8'hC3;
    bytes[1] = v[7:0];
    bytes[2] = v[15:8];
    if (ph == 0) return 11'h000;
    if (ph == 4) return {3'b011, 8'h00};
    return {3'b101, bytes[ph-1]};
  endfunction

  function automatic bit hit(logic [15:0] a, logic [15:0] b, int pg);
    return (int'(a) >= int'(b)) && (int'(a) < int'(b) + pg * 256);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic pop_cmp(logic is_we, logic [10:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected actual=%0d/%h required=none", is_we, val);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 32'(is_we), 32'(e.is_we));
      check("sb_value", 32'(val), 32'(e.val));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      obs = {inj_valid, boot_done, cpu_ready, data_out};
      if (obs !== last_obs) begin
        pop_cmp(1'b0, obs);
        last_obs = obs;
      end
      if (ram_we !== 1'b0) pop_cmp(1'b1, 11'(ram_we));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_phase(int p);
    phase = p;
    exp_q.push_back('{is_we: 1'b0, val: tup_of(p, mvec)});
  endtask

  task automatic do_reset(bit glitch);
    if (phase != 0) set_phase(0);
    reset = 1'b1;
    rd = glitch;
    wr = glitch;
    mem_init_done = 1'b0;
    tick();
    check("rst_cpu_ready", 32'(cpu_ready), 0);
    check("rst_inj_valid", 32'(inj_valid), 0);
    check("rst_boot_done", 32'(boot_done), 0);
    check("rst_data_out", 32'(data_out), 0);
    rd = 1'b0;
    wr = 1'b0;
    reset = 1'b0;
  endtask

  task automatic leave_init(bit use_to, int d);
    boot_vec = mvec;
    if (use_to) begin
      int k = 0;
      set_phase(1);
      while (cpu_ready !== 1'b1 && k < 12) begin
        tick();
        k++;
      end
      check("init_timeout_clocks_le8", 32'(k <= 8), 1);
    end else begin
      repeat (d) tick();
      mem_init_done = 1'b1;
      set_phase(1);
      tick();
      mem_init_done = 1'b0;
    end
    boot_vec = ~mvec;
  endtask

  task automatic rd_pulse(int hold, bit with_wr);
    rd = 1'b1;
    if (with_wr) begin
      wr = 1'b1;
      addr = 16'($urandom);
    end
    if (phase >= 1 && phase <= 3) set_phase(phase + 1);
    repeat (hold) tick();
    rd = 1'b0;
    wr = 1'b0;
    tick();
  endtask

  task automatic wr_pulse(logic [15:0] a);
    addr = a;
    wr = 1'b1;
    if (phase == 4 && !(WP && hit(a, BASE, PAGES)))
      exp_q.push_back('{is_we: 1'b1, val: 11'd1});
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic rom_probe(logic [15:0] a);
    addr = a;
    #1;
    check("rom_cs", 32'(rom_cs), 32'(phase == 4 && hit(a, BASE, PAGES)));
    check("rom_cs_hi", 32'(rom_cs_hi), 32'(phase == 4 && hit(a, 16'hFF00, 1)));
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return BASE + 16'($urandom_range(0, 16'h2FF));
      1:       return 16'hFF00 + 16'($urandom_range(0, 255));
      2:       return 16'($urandom_range(0, 16'hFCFF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    tick();
    tick();
    last_obs = 11'h000;
    mon_en = 1'b1;
    do_reset(1'b0);

    // directed: init done at clock 5, vector FD00, first read held 20 clocks
    mvec = 16'hFD00;
    leave_init(1'b0, 4);
    rom_probe(16'hFE00);
    rd_pulse(20, 1'b0);
    check("hold_one_advance", 32'(data_out), 32'h00);
    rd_pulse(1, 1'b0);
    rd_pulse(1, 1'b1);
    check("boot_done_after_third", 32'(boot_done), 1);
    check("inj_valid_after_third", 32'(inj_valid), 0);
    wr_pulse(16'hFD10);
    wr_pulse(16'h1000);
    rom_probe(16'hFFFF);
    rom_probe(16'h0000);
    rom_probe(16'hFD10);
    rom_probe(16'hFCFF);
    rom_probe(16'hFF00);

    // directed: timeout path, reset in JMP2, rerun starts with the opcode
    do_reset(1'b0);
    mvec = 16'h1234;
    leave_init(1'b1, 0);
    rd_pulse(1, 1'b0);
    rd_pulse(1, 1'b0);
    do_reset(1'b1);
    check("jmp2_reset_not_ready", 32'(cpu_ready), 0);
    mvec = 16'hBEEF;
    leave_init(1'b0, 2);
    check("rerun_first_byte", 32'(data_out), 32'hC3);

    for (int r = 0; r < 24; r++) begin
      bit use_to;
      int rst_at;
      bit aborted;
      use_to = ($urandom_range(0, 3) == 0);
      rst_at = $urandom_range(0, 6);
      aborted = 1'b0;
      do_reset(1'($urandom_range(0, 1)));
      mvec = 16'($urandom);
      leave_init(use_to, $urandom_range(0, 4));
      for (int p = 1; p <= 3; p++) begin
        repeat ($urandom_range(0, 3)) tick();
        if (rst_at == p) begin
          do_reset(1'($urandom_range(0, 1)));
          aborted = 1'b1;
          break;
        end
        rd_pulse($urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end
      if (!aborted) begin
        for (int w = 0; w < 4; w++) begin
          wr_pulse(pick_addr());
          repeat ($urandom_range(0, 2)) tick();
        end
        rom_probe(pick_addr());
        if (rst_at == 4) begin
          // write edge coinciding with reset must not leave a pulse behind
          addr = 16'h2000;
          do_reset(1'b1);
        end
      end
    end

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/boot_seq.md
BOOT_SEQ -- requirements
Module: boot_seq

Interface
REQ-001 SHALL have parameter JMP_OPCODE, default 8'hC3, opcode injected as first boot byte.
REQ-002 SHALL have parameter ROM_BASE, default 16'hFD00, base of the boot ROM window.
REQ-003 SHALL have parameter ROM_PAGES, default 1, ROM window size in 256-byte pages (1..16).
REQ-004 SHALL have parameter INIT_TIMEOUT, default 16'd1000, maximum clocks to wait for memory init.
REQ-005 SHALL have port clk, input, 1, single system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rd, input, 1, CPU memory-read strobe (level; each 0->1 edge is one access).
REQ-008 SHALL have port wr, input, 1, CPU memory-write strobe (level; each 0->1 edge is one access).
REQ-009 SHALL have port addr, input, 16, CPU address.
REQ-010 SHALL have port boot_vec, input, 16, jump target; sampled once on leaving INIT.
REQ-011 SHALL have port mem_init_done, input, 1, RAM/ROM loader finished.
REQ-012 SHALL have port data_out, output, 8, injected byte.
REQ-013 SHALL have port inj_valid, output, 1, data_out owns the CPU data bus.
REQ-014 SHALL have port rom_cs, output, 1, access falls in ROM window.
REQ-015 SHALL have port ram_we, output, 1, one-clock RAM write pulse.
REQ-016 SHALL have port cpu_ready, output, 1, CPU wait release.
REQ-017 SHALL have port boot_done, output, 1, boot sequence complete.

Function
REQ-018 SHALL implement FSM states INIT, JMP0, JMP1, JMP2, RUN.
REQ-019 INIT: cpu_ready=0, inj_valid=0; SHALL go to JMP0 when mem_init_done=1 or the wait counter reaches INIT_TIMEOUT-1, whichever comes first; latch boot_vec on that transition.
REQ-020 SHALL detect rd rising edges with a registered previous-rd; a rd held high counts once.
REQ-021 JMP0/JMP1/JMP2: inj_valid=1, cpu_ready=1; data_out SHALL be JMP_OPCODE, latched vec[7:0], latched vec[15:8] respectively, stable from state entry.
REQ-022 Each rd edge in JMPn SHALL advance to the next state on the following clock; a rd edge in JMP2 advances to RUN.
REQ-023 Address SHALL be ignored during JMPn; rd edges are counted irrespective of addr.
REQ-024 RUN: inj_valid=0, boot_done=1, cpu_ready=1; state SHALL be held until reset.
REQ-025 rom_cs SHALL be combinational: 1 when ROM_BASE <= addr < ROM_BASE + 256*ROM_PAGES, using 17-bit compare so the upper bound does not wrap at 16'hFFFF; rom_cs SHALL be forced 0 outside RUN.
REQ-026 ram_we SHALL pulse one clock, one clock after each wr rising edge in RUN; wr edges outside RUN SHALL be dropped.
REQ-027 Simultaneous rd and wr edges in JMPn: rd advances, wr dropped.

Reset
REQ-028 Reset SHALL force: state=INIT, wait counter=0, prev rd/wr=0, data_out=8'h00, inj_valid=0, ram_we=0, cpu_ready=0, boot_done=0.
REQ-029 Reset asserted mid-sequence, including JMP1/JMP2, SHALL restart from INIT, with no residual pulse on the following clock.

Configuration
REQ-030 With BOOT_ROM_WP_EN defined, a wr edge with rom_cs=1 SHALL NOT pulse ram_we; without it, ROM-window writes pulse ram_we like any other write.

Structure
REQ-031 Shared package boot_pkg SHALL hold the FSM state enum and the JMP_OPCODE default constant.
REQ-032 A sub-module edge_det (1-bit rising-edge detector with sync reset) SHALL be instantiated for rd and for wr.

Verification
REQ-033 Reset, mem_init_done=1 at clock 5, boot_vec=16'hFD00, three rd pulses -> data_out C3,00,FD; inj_valid falls and boot_done rises after the third.
REQ-034 mem_init_done held 0, INIT_TIMEOUT=8 -> cpu_ready rises within 8 clocks of reset release.
REQ-035 rd held high 20 clocks in JMP0 -> exactly one advance, to JMP1.
REQ-036 RUN, addr=16'hFD10, wr edge -> ram_we=0 with BOOT_ROM_WP_EN, 1 pulse without; addr=16'h1000 -> 1 pulse in both builds.
REQ-037 Reset asserted in JMP2 -> INIT next clock; rerun emits C3 first.
REQ-038 ROM_BASE=16'hFF00, addr=16'hFFFF -> rom_cs=1; addr=16'h0000 -> rom_cs=0.
